// File: rtl/pri_enc_queue.sv
// rtl/pri_enc_queue.sv - N-input sticky priority encoder with valid/ready index output
//
// Purpose: captures one-cycle request pulses into a pending register and
// presents the binary index of one pending request at a time. The
// presented request is retired when the consumer accepts it. Fixed
// priority (index 0 highest) is always available. Round-robin selection is
// compiled in only when the macro PRI_ENC_RR_EN is defined.
//
// Parameters:
//   N          number of request inputs (N >= 2)
//   W          index width, derived as $clog2(N); do not override
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        request pulses; a set bit marks that source pending
//   rr_mode    1 = round-robin, 0 = fixed priority (ignored without PRI_ENC_RR_EN)
//   out_valid  at least one request is pending
//   out_idx    index of the selected pending request (0 when nothing is pending)
//   out_ready  consumer accepts out_idx this cycle
//   pending    registered pending vector
//   ovf        registered one-cycle pulse: a request hit an already-pending bit
//              that was not being retired
module pri_enc_queue #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  logic [N-1:0] pend;
  logic [N-1:0] retire;
  logic [W-1:0] fix_idx;
  logic [W-1:0] sel_idx;
  logic         ovf_r;
  logic         accept;

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    fix_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) fix_idx = W'(i);
    end
  end

`ifdef PRI_ENC_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] rr_idx;

  // Position k steps after base, wrapping modulo N (not 2^W).
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // First pending bit at or after ptr; scanning from the far end means the
  // nearest position to ptr is written last and wins.
  always_comb begin
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[wrap_add(ptr, k)]) rr_idx = wrap_add(ptr, k);
    end
  end

  always_comb begin
    sel_idx = rr_mode ? rr_idx : fix_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && rr_mode) begin
      if (out_idx == W'(N - 1)) ptr <= '0;
      else                      ptr <= out_idx + W'(1);
    end
  end
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;

  always_comb begin
    sel_idx = fix_idx;
  end
`endif

  assign out_valid = |pend;
  assign out_idx   = out_valid ? sel_idx : '0;
  assign accept    = out_valid & out_ready;
  assign pending   = pend;
  assign ovf       = ovf_r;

  always_comb begin
    retire = '0;
    if (accept) retire[out_idx] = 1'b1;
  end

  // A set and a retire on the same bit leave it pending (set wins) and do
  // not count as overflow, because the earlier request is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      ovf_r <= 1'b0;
    end else begin
      pend  <= (pend & ~retire) | req;
      ovf_r <= |(req & pend & ~retire);
    end
  end

endmodule

// File: tb/tb_pri_enc_queue.sv
// tb/tb_pri_enc_queue.sv - directed self-checking bench for pri_enc_queue
module tb_pri_enc_queue;

  logic       clk = 1'b0;
  logic       rst;

  logic [3:0] req4;
  logic       rr4, rdy4;
  logic       vld4;
  logic [1:0] idx4;
  logic [3:0] pend4;
  logic       ovf4;

  logic [4:0] req5;
  logic       rr5, rdy5;
  logic       vld5;
  logic [2:0] idx5;
  logic [4:0] pend5;
  logic       ovf5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pri_enc_queue #(.N(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .rr_mode(rr4),
    .out_valid(vld4), .out_idx(idx4), .out_ready(rdy4),
    .pending(pend4), .ovf(ovf4)
  );

  pri_enc_queue #(.N(5)) u5 (
    .clk(clk), .rst(rst), .req(req5), .rr_mode(rr5),
    .out_valid(vld5), .out_idx(idx5), .out_ready(rdy5),
    .pending(pend5), .ovf(ovf5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req4 = '0; rr4 = 1'b0; rdy4 = 1'b0;
    req5 = '0; rr5 = 1'b0; rdy5 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(vld4), 32'd0);
    chk("idle_idx", 32'(idx4), 32'd0);
    chk("idle_pending", 32'(pend4), 32'h0);
    chk("idle_ovf", 32'(ovf4), 32'd0);

    rst = 1'b1; req4 = 4'b1111; rdy4 = 1'b1;
    tick();
    chk("rst_wins_pending", 32'(pend4), 32'h0);
    chk("rst_wins_valid", 32'(vld4), 32'd0);
    rst = 1'b0; req4 = '0; rdy4 = 1'b0;
    tick();
    chk("post_rst_pending", 32'(pend4), 32'h0);
    chk("post_rst_ovf", 32'(ovf4), 32'd0);

    // fixed-priority drain
    req4 = 4'b1010;
    tick();
    chk("drain_pend0", 32'(pend4), 32'hA);
    chk("drain_idx0", 32'(idx4), 32'd1);
    req4 = '0; rdy4 = 1'b1;
    tick();
    chk("drain_pend1", 32'(pend4), 32'h8);
    chk("drain_idx1", 32'(idx4), 32'd3);
    tick();
    chk("drain_pend2", 32'(pend4), 32'h0);
    chk("drain_valid2", 32'(vld4), 32'd0);
    chk("drain_idx2", 32'(idx4), 32'd0);
    rdy4 = 1'b0;

    // hold under backpressure, then a higher-priority arrival
    req4 = 4'b1000;
    tick();
    chk("hold_idx0", 32'(idx4), 32'd3);
    req4 = '0;
    tick();
    chk("hold_idx1", 32'(idx4), 32'd3);
    chk("hold_valid1", 32'(vld4), 32'd1);
    req4 = 4'b0001;
    tick();
    chk("preempt_idx", 32'(idx4), 32'd0);
    chk("preempt_pend", 32'(pend4), 32'h9);
    req4 = '0; rdy4 = 1'b1;
    tick();
    chk("preempt_drain_idx", 32'(idx4), 32'd3);
    tick();
    chk("preempt_drain_pend", 32'(pend4), 32'h0);
    rdy4 = 1'b0;

    // simultaneous retire and re-request, then a true overflow
    req4 = 4'b0100;
    tick();
    chk("sim_pend0", 32'(pend4), 32'h4);
    rdy4 = 1'b1;
    tick();
    chk("sim_pend1", 32'(pend4), 32'h4);
    chk("sim_no_ovf", 32'(ovf4), 32'd0);
    rdy4 = 1'b0;
    tick();
    chk("ovf_pulse", 32'(ovf4), 32'd1);
    chk("ovf_pend", 32'(pend4), 32'h4);
    req4 = '0;
    tick();
    chk("ovf_one_cycle", 32'(ovf4), 32'd0);
    rdy4 = 1'b1;
    tick();
    chk("ovf_drain", 32'(pend4), 32'h0);
    rdy4 = 1'b0;

`ifdef PRI_ENC_RR_EN
    // round-robin rotation with N=4, requests re-pulsed every cycle
    rr4 = 1'b1; req4 = 4'b1111;
    tick();
    chk("rr_idx0", 32'(idx4), 32'd0);
    rdy4 = 1'b1;
    tick();
    chk("rr_idx1", 32'(idx4), 32'd1);
    tick();
    chk("rr_idx2", 32'(idx4), 32'd2);
    tick();
    chk("rr_idx3", 32'(idx4), 32'd3);
    tick();
    chk("rr_wrap_idx", 32'(idx4), 32'd0);
    chk("rr_pend", 32'(pend4), 32'hF);
    req4 = '0; rdy4 = 1'b0; rr4 = 1'b0;

    // N=5: drive ptr to 4 by accepting index 3, then wrap modulo 5
    rr5 = 1'b1; req5 = 5'b01000;
    tick();
    chk("rr5_idx3", 32'(idx5), 32'd3);
    req5 = '0; rdy5 = 1'b1;
    tick();
    chk("rr5_empty", 32'(vld5), 32'd0);
    rdy5 = 1'b0; req5 = 5'b10001;
    tick();
    chk("rr5_idx4", 32'(idx5), 32'd4);
    req5 = '0; rdy5 = 1'b1;
    tick();
    chk("rr5_wrap_idx0", 32'(idx5), 32'd0);
    chk("rr5_pend", 32'(pend5), 32'h01);
    tick();
    chk("rr5_done_valid", 32'(vld5), 32'd0);
    chk("rr5_done_idx", 32'(idx5), 32'd0);
    rdy5 = 1'b0;
`else
    // without round-robin compiled in, rr_mode has no effect
    rr4 = 1'b1; req4 = 4'b1010;
    tick();
    chk("fixed_rr_ignored", 32'(idx4), 32'd1);
    req4 = '0; rr4 = 1'b0;

    // N=5 fixed priority never produces indices above 4
    req5 = 5'b10001;
    tick();
    chk("n5_idx0", 32'(idx5), 32'd0);
    req5 = '0; rdy5 = 1'b1;
    tick();
    chk("n5_idx4", 32'(idx5), 32'd4);
    chk("n5_pend", 32'(pend5), 32'h10);
    tick();
    chk("n5_empty", 32'(vld5), 32'd0);
    chk("n5_idx_zero", 32'(idx5), 32'd0);
    rdy5 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
